// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N:1 stream multiplexer: selection modes and the
// rotate-and-find-first search used by the round-robin arbiter.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest request vector the search function handles.
  localparam int MAX_CH = 64;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_find_t;

  // First set bit of req[0 +: n], scanning from ptr+1 upward with wrap.
  function automatic rr_find_t rr_find_first(input logic [MAX_CH-1:0] req,
                                             input int n, input int ptr);
    rr_find_t res;
    int       cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= n && !res.found) begin
        cand = (ptr + k) % n;
        if (req[cand]) begin
          res.found = 1'b1;
          res.idx   = 8'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [MAX_CH-1:0] req_ext;
  rr_find_t          res;

  always_comb begin
    req_ext   = MAX_CH'(req);
    res       = rr_find_first(req_ext, N_CH, int'(ptr));
    gnt_valid = res.found;
    gnt_idx   = SEL_W'(res.idx);
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-channel registered stream multiplexer with fixed or round-robin selection,
// valid/ready on every channel, 1-cycle latency and full throughput.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   sel_mode,
  input  logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  localparam int PAD_CH = 1 << SEL_W;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [SEL_W-1:0]  ch_p0;
  logic [SEL_W-1:0]  rr_ptr;

  logic              load_en;
  logic              rr_gnt_valid;
  logic [SEL_W-1:0]  rr_gnt_idx;
  logic              fix_gnt_valid;
  logic              gnt_valid;
  logic [SEL_W-1:0]  gnt_idx;
  logic              take;
  logic [DATA_W-1:0] gnt_data;
  logic [PAD_CH-1:0] valid_pad;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  assign load_en = !vld_p0 || out_ready;

  // Padding in_valid to a power of two lets an out-of-range sel read a zero.
  always_comb begin
    valid_pad           = '0;
    valid_pad[N_CH-1:0] = in_valid;
    fix_gnt_valid       = ({1'b0, sel} < (SEL_W+1)'(N_CH)) && valid_pad[sel];
    if (sel_mode == MODE_RR) begin
      gnt_valid = rr_gnt_valid;
      gnt_idx   = rr_gnt_idx;
    end else begin
      gnt_valid = fix_gnt_valid;
      gnt_idx   = sel;
    end
    take = rst_n && load_en && gnt_valid;
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = take;
        gnt_data    = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register stage p0 and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
      rr_ptr  <= SEL_W'(N_CH - 1);
    end else if (take) begin
      vld_p0  <= 1'b1;
      data_p0 <= gnt_data;
      ch_p0   <= gnt_idx;
      if (sel_mode == MODE_RR) rr_ptr <= gnt_idx;
    end else if (vld_p0 && out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_ch    = ch_p0;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed bench driving a 4x8 and a 3x16 multiplexer side by side, with a
// per-instance scoreboard of the words each handshake should deliver.
module tb_stream_mux_nx1;
  import stream_mux_pkg::*;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid = '0;
  logic [15:0] din [4];
  logic        mode = MODE_FIXED;
  logic [1:0]  sel = '0;
  logic        ordy = 1'b0;

  logic [31:0] a_in_data;
  logic [3:0]  a_in_ready;
  logic        a_out_valid;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic [47:0] b_in_data;
  logic [2:0]  b_in_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ch;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_ptr [2];
  int   cyc = 0;
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) a_in_data[i*8 +: 8] = din[i][7:0];
    for (int i = 0; i < 3; i++) b_in_data[i*16 +: 16] = din[i];
  end

  stream_mux_nx1 #(.N_CH(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .sel_mode(mode), .sel(sel), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ch(a_out_ch), .out_ready(ordy)
  );

  stream_mux_nx1 #(.N_CH(3), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[2:0]), .in_data(b_in_data),
    .in_ready(b_in_ready), .sel_mode(mode), .sel(sel), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_ready(ordy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare one instance against its scoreboard and work out this cycle's handshakes.
  task automatic eval(input int d, input int n, input logic [3:0] rdy, input logic vld,
                      input logic [15:0] dat, input logic [1:0] ch,
                      output bit pop, output bit push, output exp_t item);
    int   qs;
    exp_t head;
    bit   load, gv;
    int   g;
    logic [3:0]  exp_rdy;
    logic [15:0] mask;
    string       pfx;
    pfx  = (d == 0) ? "A" : "B";
    mask = (d == 0) ? 16'h00FF : 16'hFFFF;
    qs   = (d == 0) ? q0.size() : q1.size();
    head.ch = '0; head.dat = '0;
    if (qs != 0) head = (d == 0) ? q0[0] : q1[0];
    chk({pfx, " out_valid"}, 32'(vld), 32'(qs != 0));
    if (qs != 0) begin
      chk({pfx, " out_data"}, 32'(dat), 32'(head.dat));
      chk({pfx, " out_ch"}, 32'(ch), 32'(head.ch));
    end
    load = (qs == 0) || ordy;
    gv = 1'b0; g = 0;
    if (mode == MODE_FIXED) begin
      if (int'(sel) < n && valid[sel]) begin gv = 1'b1; g = int'(sel); end
    end else begin
      for (int k = 1; k <= n; k++) begin
        if (!gv && valid[(m_ptr[d] + k) % n]) begin gv = 1'b1; g = (m_ptr[d] + k) % n; end
      end
    end
    exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0000;
    chk({pfx, " in_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({pfx, " in_ready onehot0"}, 32'($onehot0(rdy)), 32'd1);
    pop  = (qs != 0) && ordy;
    push = load && gv;
    item.ch  = 2'(g);
    item.dat = din[g] & mask;
    if (push && mode == MODE_RR) m_ptr[d] = g;
  endtask

  task automatic step();
    bit pop0, push0, pop1, push1;
    exp_t it0, it1;
    #1;
    eval(0, 4, a_in_ready, a_out_valid, {8'h00, a_out_data}, a_out_ch, pop0, push0, it0);
    eval(1, 3, {1'b0, b_in_ready}, b_out_valid, b_out_data, b_out_ch, pop1, push1, it1);
    @(posedge clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (push0) q0.push_back(it0);
    if (push1) q1.push_back(it1);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic r, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      mode = m; sel = s; valid = v; ordy = r;
      for (int i = 0; i < 4; i++) din[i] = {8'(cyc), 8'(8'hA0 + i)};
      step();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " A out_valid"}, 32'(a_out_valid), 0);
    chk({tag, " A out_data"}, 32'(a_out_data), 0);
    chk({tag, " A out_ch"}, 32'(a_out_ch), 0);
    chk({tag, " A in_ready"}, 32'(a_in_ready), 0);
    chk({tag, " B out_valid"}, 32'(b_out_valid), 0);
    chk({tag, " B out_data"}, 32'(b_out_data), 0);
    chk({tag, " B in_ready"}, 32'(b_in_ready), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 16'h0;
    m_ptr[0] = 3; m_ptr[1] = 2;
    valid = 4'b1111;
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // 1. load ch2 in RR mode with the consumer stalled, then reset asynchronously
    drive(MODE_RR, 2'd0, 4'b0100, 1'b0, 2);
    chk("pre-reset A out_valid", 32'(a_out_valid), 1);
    chk("pre-reset A out_ch", 32'(a_out_ch), 2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async reset");
    q0.delete(); q1.delete();
    m_ptr[0] = 3; m_ptr[1] = 2;
    @(negedge clk);
    rst_n = 1'b1;
    drive(MODE_RR, 2'd0, 4'b1111, 1'b1, 1);
    chk("first RR grant A", 32'(a_out_ch), 0);
    chk("first RR grant B", 32'(b_out_ch), 0);
    drive(MODE_RR, 2'd0, 4'b0000, 1'b1, 2);

    // 2. fixed sel=1, all valid
    drive(MODE_FIXED, 2'd1, 4'b1111, 1'b1, 5);
    chk("fixed A out_data", 32'(a_out_data), 32'h0A1);
    chk("fixed A in_ready", 32'(a_in_ready), 32'b0010);
    // 3. fixed sel=1 with ch1 idle
    drive(MODE_FIXED, 2'd1, 4'b1101, 1'b1, 3);
    chk("fixed idle A out_valid", 32'(a_out_valid), 0);

    // 4. RR all valid, continuous drain, including wrap-around
    drive(MODE_RR, 2'd0, 4'b1111, 1'b1, 9);
    // 5. RR with a 3-cycle consumer stall mid-stream
    drive(MODE_RR, 2'd0, 4'b1111, 1'b0, 3);
    drive(MODE_RR, 2'd0, 4'b1111, 1'b1, 5);
    drive(MODE_RR, 2'd0, 4'b1011, 1'b1, 4);
    drive(MODE_RR, 2'd0, 4'b0000, 1'b1, 2);

    // 6. sel out of range for the 3-channel instance, then round-robin
    drive(MODE_FIXED, 2'd3, 4'b0111, 1'b1, 3);
    chk("sel=3 B out_valid", 32'(b_out_valid), 0);
    drive(MODE_RR, 2'd3, 4'b0111, 1'b1, 7);
    drive(MODE_RR, 2'd0, 4'b0000, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
